// File: rtl/axi4_lite_slave_regs_pkg.sv
// Shared definitions for the AXI4-Lite slave register bank: response codes,
// write/read FSM state types and the byte-strobe merge helper.
package axi4_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE,
    W_WAIT_DATA,
    W_WAIT_ADDR,
    W_RESP
  } wr_state_e;

  typedef enum logic {
    R_IDLE,
    R_RESP
  } rd_state_e;

  function automatic logic [31:0] strb_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    for (int unsigned b = 0; b < 4; b++)
      res[8*b +: 8] = strb[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
    return res;
  endfunction

endpackage

// File: rtl/axi4_lite_slave_wr_ctrl.sv
// AXI4-Lite write-channel FSM: accepts AW and W in either order, then emits
// a one-cycle commit with the decoded index, data, strobes and in-range flag.
module axi4_lite_slave_wr_ctrl
  import axi4_lite_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned NB_REG     = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] i_awaddr,
  input  logic                  i_awvalid,
  output logic                  o_awready,
  input  logic [31:0]           i_wdata,
  input  logic [3:0]            i_wstrb,
  input  logic                  i_wvalid,
  output logic                  o_wready,
  output logic [1:0]            o_bresp,
  output logic                  o_bvalid,
  input  logic                  i_bready,
  output logic                  o_commit,
  output logic [ADDR_WIDTH-3:0] o_index,
  output logic [31:0]           o_data,
  output logic [3:0]            o_strb,
  output logic                  o_okay
);

  wr_state_e             r_state;
  logic                  r_awready;
  logic                  r_wready;
  logic                  r_bvalid;
  logic [1:0]            r_bresp;
  logic [ADDR_WIDTH-3:0] r_index;
  logic [31:0]           r_data;
  logic [3:0]            r_strb;

  logic                  w_aw_hs;
  logic                  w_w_hs;
  logic [1:0]            w_resp;
  logic                  w_unused_addr;

  assign w_aw_hs       = i_awvalid & r_awready;
  assign w_w_hs        = i_wvalid & r_wready;
  assign w_unused_addr = ^i_awaddr[1:0];

  // Commit-cycle operands come from the live bus or from whichever half was latched earlier.
  always_comb begin
    o_index  = (r_state == W_WAIT_DATA) ? r_index : i_awaddr[ADDR_WIDTH-1:2];
    o_data   = (r_state == W_WAIT_ADDR) ? r_data  : i_wdata;
    o_strb   = (r_state == W_WAIT_ADDR) ? r_strb  : i_wstrb;
    o_okay   = ({2'b00, o_index} < ADDR_WIDTH'(NB_REG));
    w_resp   = o_okay ? RESP_OKAY : RESP_SLVERR;
    o_commit = 1'b0;
    unique case (r_state)
      W_IDLE:      o_commit = w_aw_hs & w_w_hs;
      W_WAIT_DATA: o_commit = w_w_hs;
      W_WAIT_ADDR: o_commit = w_aw_hs;
      default:     o_commit = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= W_IDLE;
      r_awready <= 1'b1;
      r_wready  <= 1'b1;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OKAY;
      r_index   <= '0;
      r_data    <= '0;
      r_strb    <= '0;
    end else begin
      unique case (r_state)
        W_IDLE, W_WAIT_DATA, W_WAIT_ADDR: begin
          if (o_commit) begin
            r_state   <= W_RESP;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b1;
            r_bresp   <= w_resp;
          end else if (r_state == W_IDLE && w_aw_hs) begin
            r_state   <= W_WAIT_DATA;
            r_awready <= 1'b0;
            r_index   <= i_awaddr[ADDR_WIDTH-1:2];
          end else if (r_state == W_IDLE && w_w_hs) begin
            r_state   <= W_WAIT_ADDR;
            r_wready  <= 1'b0;
            r_data    <= i_wdata;
            r_strb    <= i_wstrb;
          end
        end
        W_RESP: begin
          if (i_bready) begin
            r_state   <= W_IDLE;
            r_awready <= 1'b1;
            r_wready  <= 1'b1;
            r_bvalid  <= 1'b0;
          end
        end
        default: r_state <= W_IDLE;
      endcase
    end
  end

  assign o_awready = r_awready;
  assign o_wready  = r_wready;
  assign o_bvalid  = r_bvalid;
  assign o_bresp   = r_bresp;

endmodule

// File: rtl/axi4_lite_slave_regs.sv
// AXI4-Lite slave holding NB_REG 32-bit control registers with OKAY/SLVERR decode.
// Optional macro AXI4_LITE_SLAVE_WR_PULSE_EN adds o_wr_pulse, one cycle per OKAY commit.
module axi4_lite_slave_regs
  import axi4_lite_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned NB_REG     = 16,
  parameter logic [31:0] RST_VALUE  = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [ADDR_WIDTH-1:0]  s_awaddr,
  input  logic                   s_awvalid,
  output logic                   s_awready,
  input  logic [31:0]            s_wdata,
  input  logic [3:0]             s_wstrb,
  input  logic                   s_wvalid,
  output logic                   s_wready,
  output logic [1:0]             s_bresp,
  output logic                   s_bvalid,
  input  logic                   s_bready,
  input  logic [ADDR_WIDTH-1:0]  s_araddr,
  input  logic                   s_arvalid,
  output logic                   s_arready,
  output logic [31:0]            s_rdata,
  output logic [1:0]             s_rresp,
  output logic                   s_rvalid,
  input  logic                   s_rready,
`ifdef AXI4_LITE_SLAVE_WR_PULSE_EN
  output logic [NB_REG-1:0]      o_wr_pulse,
`endif
  output logic [NB_REG*32-1:0]   o_regs
);

  logic [31:0]           r_regs [NB_REG];
  rd_state_e             r_rstate;
  logic                  r_arready;
  logic                  r_rvalid;
  logic [31:0]           r_rdata;
  logic [1:0]            r_rresp;

  logic                  w_commit;
  logic [ADDR_WIDTH-3:0] w_wr_index;
  logic [31:0]           w_wr_data;
  logic [3:0]            w_wr_strb;
  logic                  w_wr_okay;
  logic [ADDR_WIDTH-3:0] w_ar_index;
  logic                  w_ar_okay;
  logic [31:0]           w_rd_val;
  logic                  w_unused_araddr;

  axi4_lite_slave_wr_ctrl #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NB_REG     (NB_REG)
  ) u_wr_ctrl (
    .clk       (clk),
    .rst       (rst),
    .i_awaddr  (s_awaddr),
    .i_awvalid (s_awvalid),
    .o_awready (s_awready),
    .i_wdata   (s_wdata),
    .i_wstrb   (s_wstrb),
    .i_wvalid  (s_wvalid),
    .o_wready  (s_wready),
    .o_bresp   (s_bresp),
    .o_bvalid  (s_bvalid),
    .i_bready  (s_bready),
    .o_commit  (w_commit),
    .o_index   (w_wr_index),
    .o_data    (w_wr_data),
    .o_strb    (w_wr_strb),
    .o_okay    (w_wr_okay)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned k = 0; k < NB_REG; k++) r_regs[k] <= RST_VALUE;
    end else if (w_commit && w_wr_okay) begin
      for (int unsigned k = 0; k < NB_REG; k++)
        if (w_wr_index == (ADDR_WIDTH-2)'(k))
          r_regs[k] <= strb_merge(r_regs[k], w_wr_data, w_wr_strb);
    end
  end

  assign w_ar_index      = s_araddr[ADDR_WIDTH-1:2];
  assign w_ar_okay       = ({2'b00, w_ar_index} < ADDR_WIDTH'(NB_REG));
  assign w_unused_araddr = ^s_araddr[1:0];

  // Out-of-range indices match no register, so the read value falls back to zero.
  always_comb begin
    w_rd_val = '0;
    for (int unsigned k = 0; k < NB_REG; k++)
      if (w_ar_index == (ADDR_WIDTH-2)'(k)) w_rd_val = r_regs[k];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rstate  <= R_IDLE;
      r_arready <= 1'b1;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
      r_rresp   <= RESP_OKAY;
    end else begin
      unique case (r_rstate)
        R_IDLE: begin
          if (s_arvalid) begin
            r_rstate  <= R_RESP;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b1;
            r_rdata   <= w_rd_val;
            r_rresp   <= w_ar_okay ? RESP_OKAY : RESP_SLVERR;
          end
        end
        R_RESP: begin
          if (s_rready) begin
            r_rstate  <= R_IDLE;
            r_arready <= 1'b1;
            r_rvalid  <= 1'b0;
          end
        end
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

  assign s_arready = r_arready;
  assign s_rvalid  = r_rvalid;
  assign s_rdata   = r_rdata;
  assign s_rresp   = r_rresp;

  always_comb begin
    o_regs = '0;
    for (int unsigned k = 0; k < NB_REG; k++) o_regs[32*k +: 32] = r_regs[k];
  end

`ifdef AXI4_LITE_SLAVE_WR_PULSE_EN
  logic [NB_REG-1:0] r_wr_pulse;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_pulse <= '0;
    end else begin
      for (int unsigned k = 0; k < NB_REG; k++)
        r_wr_pulse[k] <= w_commit & w_wr_okay & (w_wr_index == (ADDR_WIDTH-2)'(k));
    end
  end

  assign o_wr_pulse = r_wr_pulse;
`endif

endmodule

// File: tb/tb_axi4_lite_slave_regs.sv
// Scoreboard bench for axi4_lite_slave_regs: directed plan items plus random traffic
// against an array model of the register bank.
module tb_axi4_lite_slave_regs;

  localparam int unsigned AW  = 8;
  localparam int unsigned NB  = 16;
  localparam int unsigned TMO = 40;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [AW-1:0]    s_awaddr = '0;
  logic             s_awvalid = 1'b0;
  logic             s_awready;
  logic [31:0]      s_wdata = '0;
  logic [3:0]       s_wstrb = '0;
  logic             s_wvalid = 1'b0;
  logic             s_wready;
  logic [1:0]       s_bresp;
  logic             s_bvalid;
  logic             s_bready = 1'b0;
  logic [AW-1:0]    s_araddr = '0;
  logic             s_arvalid = 1'b0;
  logic             s_arready;
  logic [31:0]      s_rdata;
  logic [1:0]       s_rresp;
  logic             s_rvalid;
  logic             s_rready = 1'b0;
  logic [NB*32-1:0] o_regs;
`ifdef AXI4_LITE_SLAVE_WR_PULSE_EN
  logic [NB-1:0]    o_wr_pulse;
`endif

  axi4_lite_slave_regs #(
    .ADDR_WIDTH (AW),
    .NB_REG     (NB),
    .RST_VALUE  (32'h0000_0000)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .s_awaddr  (s_awaddr),
    .s_awvalid (s_awvalid),
    .s_awready (s_awready),
    .s_wdata   (s_wdata),
    .s_wstrb   (s_wstrb),
    .s_wvalid  (s_wvalid),
    .s_wready  (s_wready),
    .s_bresp   (s_bresp),
    .s_bvalid  (s_bvalid),
    .s_bready  (s_bready),
    .s_araddr  (s_araddr),
    .s_arvalid (s_arvalid),
    .s_arready (s_arready),
    .s_rdata   (s_rdata),
    .s_rresp   (s_rresp),
    .s_rvalid  (s_rvalid),
    .s_rready  (s_rready),
`ifdef AXI4_LITE_SLAVE_WR_PULSE_EN
    .o_wr_pulse(o_wr_pulse),
`endif
    .o_regs    (o_regs)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] model [NB];
  logic [1:0]  bq [$];
  logic [33:0] rq [$];

  task automatic chk(input string name, input logic [NB*32-1:0] act, input logic [NB*32-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s timeout actual=no_ready required=ready", name);
  endtask

  function automatic logic [NB*32-1:0] model_flat();
    logic [NB*32-1:0] v;
    for (int unsigned k = 0; k < NB; k++) v[32*k +: 32] = model[k];
    return v;
  endfunction

  function automatic int unsigned idx_of(input logic [7:0] a);
    return {26'b0, a[7:2]};
  endfunction

  // Scoreboard monitor: compares responses whenever a handshake is about to occur.
  always @(negedge clk) begin
    if (!rst && s_bvalid && s_bready) begin
      if (bq.size() == 0) begin
        checks++; errors++;
        $display("FAIL b_unexpected actual=bresp_%0h required=none", s_bresp);
      end else chk("bresp", s_bresp, bq.pop_front());
    end
    if (!rst && s_rvalid && s_rready) begin
      if (rq.size() == 0) begin
        checks++; errors++;
        $display("FAIL r_unexpected actual=rdata_%0h required=none", s_rdata);
      end else chk("rdata_rresp", {s_rdata, s_rresp}, rq.pop_front());
    end
  end

  task automatic aw_send(input logic [7:0] a);
    int unsigned n = 0;
    s_awaddr = a; s_awvalid = 1'b1;
    @(negedge clk);
    while (!s_awready && n < TMO) begin @(negedge clk); n++; end
    if (n >= TMO) timeout("aw");
    @(posedge clk); #1; s_awvalid = 1'b0;
  endtask

  task automatic w_send(input logic [31:0] d, input logic [3:0] s);
    int unsigned n = 0;
    s_wdata = d; s_wstrb = s; s_wvalid = 1'b1;
    @(negedge clk);
    while (!s_wready && n < TMO) begin @(negedge clk); n++; end
    if (n >= TMO) timeout("w");
    @(posedge clk); #1; s_wvalid = 1'b0;
  endtask

  task automatic ar_send(input logic [7:0] a);
    int unsigned n = 0;
    s_araddr = a; s_arvalid = 1'b1;
    @(negedge clk);
    while (!s_arready && n < TMO) begin @(negedge clk); n++; end
    if (n >= TMO) timeout("ar");
    @(posedge clk); #1; s_arvalid = 1'b0;
  endtask

  task automatic b_take(input logic [1:0] exp_resp, input int unsigned dly);
    for (int unsigned k = 0; k < dly; k++) begin
      @(negedge clk);
      chk("b_hold", {s_bvalid, s_bresp, s_awready, s_wready}, {1'b1, exp_resp, 2'b00});
      @(posedge clk); #1;
    end
    s_bready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    s_bready = 1'b0;
  endtask

  task automatic do_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int unsigned aw_dly, input int unsigned w_dly, input int unsigned b_dly);
    int unsigned   idx = idx_of(a);
    logic [1:0]    exp_resp;
    logic [NB-1:0] exp_pulse = '0;
    if (idx < NB) begin
      for (int unsigned b = 0; b < 4; b++)
        if (s[b]) model[idx][8*b +: 8] = d[8*b +: 8];
      exp_resp = 2'b00;
      exp_pulse[idx] = 1'b1;
    end else exp_resp = 2'b10;
    bq.push_back(exp_resp);
    fork
      begin
        for (int unsigned k = 0; k < aw_dly; k++) begin
          @(negedge clk);
          if (k >= w_dly + 1) chk("wait_addr_ready", {s_awready, s_wready}, 2'b10);
          @(posedge clk); #1;
        end
        aw_send(a);
      end
      begin
        for (int unsigned k = 0; k < w_dly; k++) begin
          @(negedge clk);
          if (k >= aw_dly + 1) chk("wait_data_ready", {s_awready, s_wready}, 2'b01);
          @(posedge clk); #1;
        end
        w_send(d, s);
      end
    join
    @(negedge clk);
    chk("bvalid_commit", s_bvalid, 1'b1);
    chk("regs_commit", o_regs, model_flat());
`ifdef AXI4_LITE_SLAVE_WR_PULSE_EN
    chk("pulse_commit", o_wr_pulse, exp_pulse);
    @(posedge clk); #1;
    @(negedge clk);
    chk("pulse_clear", o_wr_pulse, '0);
`endif
    @(posedge clk); #1;
    b_take(exp_resp, b_dly);
  endtask

  task automatic do_read(input logic [7:0] a, input logic [31:0] exp_d, input logic [1:0] exp_r,
                         input int unsigned dly);
    rq.push_back({exp_d, exp_r});
    ar_send(a);
    @(negedge clk);
    chk("rvalid_latency", s_rvalid, 1'b1);
    @(posedge clk); #1;
    for (int unsigned k = 0; k < dly; k++) begin
      @(negedge clk);
      chk("r_hold", {s_rvalid, s_rdata, s_rresp, s_arready}, {1'b1, exp_d, exp_r, 1'b0});
      @(posedge clk); #1;
    end
    s_rready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    s_rready = 1'b0;
  endtask

  task automatic do_read_m(input logic [7:0] a, input int unsigned dly);
    int unsigned idx = idx_of(a);
    if (idx < NB) do_read(a, model[idx], 2'b00, dly);
    else          do_read(a, 32'h0, 2'b10, dly);
  endtask

  task automatic check_reset(input string name);
    chk({name, "_ctl"}, {s_awready, s_wready, s_bvalid, s_bresp, s_arready, s_rvalid, s_rresp},
        {1'b1, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 2'b00});
    chk({name, "_rdata"}, s_rdata, 32'h0);
    chk({name, "_regs"}, o_regs, model_flat());
`ifdef AXI4_LITE_SLAVE_WR_PULSE_EN
    chk({name, "_pulse"}, o_wr_pulse, '0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp_old;
    logic [7:0]  a;
    for (int unsigned k = 0; k < NB; k++) model[k] = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check_reset("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    do_write(8'h04, 32'hDEADBEEF, 4'hF, 0, 0, 0);
    chk("reg1_direct", o_regs[63:32], 32'hDEADBEEF);
    do_read_m(8'h04, 0);

    do_write(8'h08, 32'h12345678, 4'b0101, 0, 3, 0);
    chk("reg2_aw_first", o_regs[95:64], 32'h00340078);
    do_write(8'h08, 32'h0, 4'hF, 0, 0, 0);
    do_write(8'h08, 32'h12345678, 4'b0101, 3, 0, 0);
    chk("reg2_w_first", o_regs[95:64], 32'h00340078);

    do_write(8'h40, 32'hA5A5A5A5, 4'hF, 0, 0, 0);
    do_read(8'h40, 32'h0, 2'b10, 0);
    do_write(8'h10, 32'hFFFFFFFF, 4'h0, 0, 0, 0);

    do_write(8'h0C, 32'h01020304, 4'hF, 1, 0, 5);
    do_read_m(8'h0C, 4);

    do_write(8'h04, 32'h11111111, 4'hF, 0, 0, 0);
    exp_old = model[1];
    fork
      do_write(8'h04, 32'h22222222, 4'hF, 0, 0, 0);
      do_read(8'h04, exp_old, 2'b00, 0);
    join
    do_read(8'h04, 32'h22222222, 2'b00, 0);

    s_awaddr = 8'h08; s_awvalid = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    s_awvalid = 1'b0;
    @(negedge clk);
    chk("aw_accepted", s_awready, 1'b0);
    rst = 1'b1;
    #1;
    for (int unsigned k = 0; k < NB; k++) model[k] = 32'h0;
    check_reset("midreset");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    do_write(8'h08, 32'hCAFEF00D, 4'b0011, 0, 0, 0);
    do_read_m(8'h08, 1);

    for (int i = 0; i < 60; i++) begin
      a = 8'($urandom_range(0, 79));
      do_write(a, $urandom, 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
               $urandom_range(0, 2));
      a = 8'($urandom_range(0, 79));
      do_read_m(a, $urandom_range(0, 2));
    end

    repeat (3) @(posedge clk);
    chk("bq_drained", bq.size(), 0);
    chk("rq_drained", rq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
